// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed, active-low 7-segment scan bus into full 8-digit frames.
// Tracks a single rotating square across frames and infers its rotation direction.

// Per-digit classifier: spots the upper/lower square glyphs and maps them to a ring position.
module seg_slot_class (
    input  logic [6:0] pattern,
    input  logic [2:0] idx,
    output logic       is_sq,
    output logic       is_blank,
    output logic [3:0] pos
);
    logic upper;
    logic lower;

    assign upper    = (pattern == 7'h63);
    assign lower    = (pattern == 7'h5C);
    assign is_sq    = upper | lower;
    assign is_blank = (pattern == 7'h00);
    // Lower squares run backwards along the ring: 15-k == {1, ~k} for k in 0..7
    assign pos      = upper ? {1'b0, idx} : {1'b1, ~idx};
endmodule

module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [7:0]  digit,
    output logic [63:0] frame,
    output logic        frame_valid,
    output logic        sq_found,
    output logic [3:0]  sq_pos,
    output logic        dir_cw,
    output logic        dir_valid,
    output logic        err
);
    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    typedef enum logic [1:0] {NO_REF, HAVE_REF, LOCKED} dir_state_t;

    logic [7:0]       seg_s1, seg_s2, digit_s1, digit_s2;
    logic [15:0]      bus_prev;
    logic [3:0]       stab_cnt, stab_cnt_n;
    logic             capture, one_hot, cap_wr, cap_bad, load;
    logic [7:0]       dig_inv;
    logic [2:0]       cap_idx;
    logic [7:0][7:0]  slots;
    logic [7:0]       seen, seen_n;
    logic [7:0]       sq_vec, blank_vec;
    logic [7:0][3:0]  pos_vec;
    logic [3:0]       sq_cnt, pos_c;
    logic             all_ok, found_c;
    dir_state_t       state, state_n;
    logic [3:0]       p_prev, p_prev_n;
    logic             dir_cw_n;

    // Stability counter: restarts on any change, captures once when it first saturates
    always_comb begin
        stab_cnt_n = stab_cnt;
        if ({digit_s2, seg_s2} != bus_prev)
            stab_cnt_n = 4'd0;
        else if (stab_cnt != STABLE)
            stab_cnt_n = stab_cnt + 4'd1;
    end

    assign capture = (stab_cnt_n == STABLE) && (stab_cnt != STABLE);
    assign dig_inv = ~digit_s2;
    assign one_hot = (dig_inv != 8'd0) && ((dig_inv & (dig_inv - 8'd1)) == 8'd0);
    assign cap_wr  = capture && one_hot;
    assign cap_bad = capture && !one_hot && (digit_s2 != 8'hFF);
    assign load    = (seen == 8'hFF);

    always_comb begin
        cap_idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (dig_inv[i]) cap_idx = 3'(i);
    end

    // A capture coinciding with a frame load lands in the freshly cleared seen vector
    always_comb begin
        seen_n = load ? 8'd0 : seen;
        if (cap_wr) seen_n[cap_idx] = 1'b1;
    end

    for (genvar g = 0; g < 8; g++) begin : g_cls
        seg_slot_class u_cls (
            .pattern (slots[g][6:0]),
            .idx     (3'(g)),
            .is_sq   (sq_vec[g]),
            .is_blank(blank_vec[g]),
            .pos     (pos_vec[g])
        );
    end

    always_comb begin
        sq_cnt = 4'd0;
        pos_c  = 4'd0;
        all_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (sq_vec[i]) begin
                sq_cnt = sq_cnt + 4'd1;
                pos_c  = pos_c | pos_vec[i];
            end
            if (!(sq_vec[i] || blank_vec[i])) all_ok = 1'b0;
        end
        found_c = all_ok && (sq_cnt == 4'd1);
    end

    always_comb begin
        state_n  = state;
        p_prev_n = p_prev;
        dir_cw_n = dir_cw;
        if (load) begin
            if (!found_c) begin
                state_n = NO_REF;
            end else begin
                p_prev_n = pos_c;
                if (state == NO_REF) begin
                    state_n = HAVE_REF;
                end else if (pos_c == p_prev + 4'd1) begin
                    state_n  = LOCKED;
                    dir_cw_n = 1'b1;
                end else if (pos_c == p_prev - 4'd1) begin
                    state_n  = LOCKED;
                    dir_cw_n = 1'b0;
                end else if (pos_c != p_prev) begin
                    state_n = HAVE_REF;
                end
            end
        end
    end

    assign dir_valid = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1      <= 8'hFF;
            seg_s2      <= 8'hFF;
            digit_s1    <= 8'hFF;
            digit_s2    <= 8'hFF;
            bus_prev    <= 16'hFFFF;
            stab_cnt    <= 4'd0;
            slots       <= '0;
            seen        <= 8'd0;
            frame       <= 64'd0;
            frame_valid <= 1'b0;
            sq_found    <= 1'b0;
            sq_pos      <= 4'd0;
            err         <= 1'b0;
            state       <= NO_REF;
            p_prev      <= 4'd0;
            dir_cw      <= 1'b0;
        end else begin
            seg_s1      <= seg;
            seg_s2      <= seg_s1;
            digit_s1    <= digit;
            digit_s2    <= digit_s1;
            bus_prev    <= {digit_s2, seg_s2};
            stab_cnt    <= stab_cnt_n;
            err         <= cap_bad;
            frame_valid <= load;
            seen        <= seen_n;
            state       <= state_n;
            p_prev      <= p_prev_n;
            dir_cw      <= dir_cw_n;
            if (load) begin
                frame    <= slots;
                sq_found <= found_c;
                if (found_c) sq_pos <= pos_c;
            end
            if (cap_wr) slots[cap_idx] <= ~seg_s2;
        end
    end
endmodule
